lut_ln: RTL and testbench
=========================

# lut_ln

Iterative fixed-point natural-log unit: the inverse of the LUT exponential block. It converts a probability-domain value y in (0,1], Q0.32 (the exponential block's output format), back to x = −ln(y) in Q16.16 with x < 16, so bits [31:20] are always zero (the exponential block's input format). It sits in the softmax compute datapath for log-softmax and for round-trip checking of the exp path. It resolves one result bit per cycle against the same 20-entry e^-(2^k) table, using the same truncating multiply chain as the exponential block.

## Interface
- data_size, 32, width of input and output data words; only 32 is supported.
- clock_i  in  1  clock, rising edge.
- reset_n_i  in  1  asynchronous, active-low reset.
- ln_valid_i  in  1  input word valid.
- ln_data_i  in  data_size  y, unsigned Q0.32; 32'hFFFFFFFF represents 1.0.
- ln_ready_o  out  1  block can accept a new input (IDLE only).
- ln_data_valid_o  out  1  result valid, held until consumed.
- ln_data_o  out  data_size  x = −ln(y), unsigned Q16.16, bits [31:20] = 0.
- ln_sat_o  out  1  y was 0; the result is saturated. Qualified by ln_data_valid_o.
- ln_ready_i  in  1  downstream accepts the result.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE:
  - ln_ready_o = 1.
  - On ln_valid_i, capture y and go to the matching case below.
- Case y == 0: x = 32'h000FFFFF, ln_sat_o = 1, go to DONE.
- Case y == 32'hFFFFFFFF: x = 0, go to DONE.
- Otherwise: clear x, set the running product r = 0 ("empty"), set k = 19, go to BUSY.
- BUSY, one k per cycle:
  - Candidate c = (r == 0) ? {LUT[k], 16'b0} : r[31:16] * LUT[k], a 16×16 → 32-bit multiply.
  - If c >= y: r <= c and x[k] <= 1. Otherwise r and x are unchanged.
  - If k == 0, go to DONE; else k <= k − 1.
- LUT[k] = e^-(2^(k−16)) in unsigned Q0.16, identical to the exponential block's table:
  - LUT[19..16] = 0015, 04B0, 22A5, 5E2D
  - LUT[15..8] = 9B45, C75F, E1EB, F07D, F81F, FC07, FE01, FF00
  - LUT[7..0] = FF80, FFC0, FFE0, FFF0, FFF8, FFFC, FFFE, FFFF
- Greedy result: x is the largest value that the exponential block's truncated chain maps to a result >= y.
- DONE:
  - ln_data_valid_o = 1; ln_data_o and ln_sat_o are stable.
  - On ln_ready_i, go to IDLE.
- ln_valid_i is ignored outside IDLE; an upstream holding valid waits on ln_ready_o.
- Arithmetic: r and c are 32 bits, unsigned. Products truncate, never round. x bits [31:20] are never written.

## Timing
- Reset (asynchronous assert, synchronous deassert handled upstream) sets:
  - state = IDLE, x = 0, r = 0, k = 19.
  - ln_ready_o = 1, ln_data_valid_o = 0, ln_data_o = 0, ln_sat_o = 0.
- Reset during BUSY or DONE aborts the operation immediately; the in-flight result is discarded with no valid pulse.
- Input is accepted on the edge where ln_valid_i && ln_ready_o.
- General case latency:
  - 20 BUSY cycles, then DONE.
  - ln_data_valid_o rises 21 cycles after the accept edge.
- Special cases (y = 0, y = all-ones): ln_data_valid_o rises 1 cycle after accept.
- Result transfer occurs on the edge where ln_data_valid_o && ln_ready_i. The next cycle is IDLE with ln_ready_o = 1.
- Throughput: at most one result per 22 cycles (general case). Result-consume and new-accept cannot coincide: one-cycle bubble by design.
- ln_data_o and ln_sat_o are registered and change only on the DONE entry edge. Between results they hold the last value.

## Structure
- Shared package softmax_pkg contains:
  - LUT_EXP_DEPTH = 20.
  - LUT_EXP_W = 16.
  - The 20 LUT constants.
  - FXP_FRAC_BITS = 16.
  - LN_SAT_VALUE = 32'h000FFFFF.
- The exponential block migrates to the same constants.
- Sub-module lut_exp_rom: combinational, 5-bit index → 16-bit constant. It is shared with the exponential block.
- The multiplier is a single 16×16 instance, reused across iterations.

## Test plan
- Reset, then y = 32'hFFFFFFFF: ln_data_valid_o one cycle after accept; ln_data_o = 0, ln_sat_o = 0.
- y = 0: ln_data_o = 32'h000FFFFF, ln_sat_o = 1, one-cycle latency.
- y = 32'h5E2D0000 (e^-1): ln_data_o = 32'h00010000, valid exactly 21 cycles after accept.
- Round trip: sweep x over 0..32'h000FFFFF (random plus all single bits) through the exponential-block golden model, feed y:
  - ln_data_o >= x.
  - The exp model of ln_data_o equals y.
- Backpressure: hold ln_ready_i = 0 for 10 cycles in DONE:
  - Output stays stable.
  - ln_ready_o = 0.
  - A new ln_valid_i is not accepted until one cycle after ln_ready_i.
- Assert reset_n_i low mid-BUSY (k = 10):
  - All outputs go to reset values asynchronously.
  - The next input after reset computes correctly.

Source files
------------

// File: rtl/lut_ln_pkg.sv
`default_nettype none
// ============================================================================
//  Package   : softmax_pkg
//  Purpose   : Constants shared by the softmax datapath: the e^-(2^(k-16))
//              table used by both the exponential and natural-log blocks,
//              fixed-point format constants and the log-block FSM encoding.
//  Revision  : 1.0 - initial release
// ============================================================================
package softmax_pkg;

  localparam int LUT_EXP_DEPTH = 20;
  localparam int LUT_EXP_W     = 16;
  localparam int LUT_IDX_W     = 5;
  localparam int FXP_FRAC_BITS = 16;

  localparam logic [31:0] LN_SAT_VALUE = 32'h000F_FFFF;

  // Entry k (k = 0..19) sits at bits [k*16 +: 16]; value is e^-(2^(k-16))
  // in unsigned Q0.16. Listed most-significant entry (k = 19) first.
  localparam logic [LUT_EXP_DEPTH*LUT_EXP_W-1:0] LUT_EXP_TABLE = {
    16'h0015, 16'h04B0, 16'h22A5, 16'h5E2D,
    16'h9B45, 16'hC75F, 16'hE1EB, 16'hF07D,
    16'hF81F, 16'hFC07, 16'hFE01, 16'hFF00,
    16'hFF80, 16'hFFC0, 16'hFFE0, 16'hFFF0,
    16'hFFF8, 16'hFFFC, 16'hFFFE, 16'hFFFF
  };

  typedef enum logic [1:0] {
    LN_IDLE = 2'd0,
    LN_BUSY = 2'd1,
    LN_DONE = 2'd2
  } ln_state_t;

  // Out-of-range indices read as zero so the table is total over 5 bits.
  function automatic logic [LUT_EXP_W-1:0] lut_exp_value(input logic [LUT_IDX_W-1:0] idx);
    logic [LUT_EXP_W-1:0] value;
    value = '0;
    if (int'(idx) < LUT_EXP_DEPTH) begin
      value = LUT_EXP_TABLE[int'(idx)*LUT_EXP_W +: LUT_EXP_W];
    end
    return value;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lut_ln_if.sv
`default_nettype none
// ============================================================================
//  Interface : lut_ln_if
//  Purpose   : Request/response handshake of the natural-log block.
//  Signals   : ln_valid_i / ln_data_i / ln_ready_o  - input word handshake
//              ln_data_valid_o / ln_data_o / ln_sat_o / ln_ready_i
//                                                   - result handshake
//  Modports  : master (producer/consumer side), slave (the log block)
//  Revision  : 1.0 - initial release
// ============================================================================
interface lut_ln_if #(
  parameter int DATA_SIZE = 32
) ();

  logic                 ln_valid_i;
  logic [DATA_SIZE-1:0] ln_data_i;
  logic                 ln_ready_o;
  logic                 ln_data_valid_o;
  logic [DATA_SIZE-1:0] ln_data_o;
  logic                 ln_sat_o;
  logic                 ln_ready_i;

  modport master (
    output ln_valid_i, ln_data_i, ln_ready_i,
    input  ln_ready_o, ln_data_valid_o, ln_data_o, ln_sat_o
  );

  modport slave (
    input  ln_valid_i, ln_data_i, ln_ready_i,
    output ln_ready_o, ln_data_valid_o, ln_data_o, ln_sat_o
  );

endinterface
`default_nettype wire

// File: rtl/lut_exp_rom.sv
`default_nettype none
// ============================================================================
//  Module    : lut_exp_rom
//  Purpose   : Combinational e^-(2^(k-16)) table, Q0.16, shared by the
//              exponential and natural-log blocks.
//  Ports     : idx   in  5   table index k (0..19, others read 0)
//              value out 16  table entry
//  Revision  : 1.0 - initial release
// ============================================================================
module lut_exp_rom
  import softmax_pkg::*;
(
  input  logic [LUT_IDX_W-1:0] idx,
  output logic [LUT_EXP_W-1:0] value
);

  always_comb begin
    value = lut_exp_value(idx);
  end

endmodule
`default_nettype wire

// File: rtl/lut_ln.sv
`default_nettype none
// ============================================================================
//  Module    : lut_ln
//  Purpose   : Iterative natural log. Takes y in (0,1] as unsigned Q0.32 and
//              returns x = -ln(y) as unsigned Q16.16 (x < 16), one result bit
//              per cycle, MSB first, using the exponential block's truncated
//              multiply chain so that exp(ln(y)) round-trips.
//  Ports     : clock_i    in  clock, rising edge
//              reset_n_i  in  asynchronous active-low reset
//              ln         lut_ln_if.slave (input word + result handshakes)
//  Revision  : 1.0 - initial release
// ============================================================================
module lut_ln
  import softmax_pkg::*;
(
  input  logic       clock_i,
  input  logic       reset_n_i,
  lut_ln_if.slave    ln
);

  localparam logic [LUT_IDX_W-1:0] K_START = LUT_IDX_W'(LUT_EXP_DEPTH - 1);
  localparam int                   X_W     = LUT_EXP_DEPTH;

  ln_state_t            state;
  logic [31:0]          y_q;
  logic [X_W-1:0]       x_q;
  logic [31:0]          r_q;
  logic [LUT_IDX_W-1:0] k_q;
  logic [31:0]          data_q;
  logic                 sat_q;
  logic                 valid_q;
  logic                 ready_q;

  logic [LUT_EXP_W-1:0] lut_val;
  logic [31:0]          prod;
  logic [31:0]          cand;
  logic                 take;
  logic [X_W-1:0]       x_next;

  lut_exp_rom u_rom (
    .idx   (k_q),
    .value (lut_val)
  );

  // The single 16x16 multiplier, reused for every iteration.
  assign prod = {16'b0, r_q[31:16]} * {16'b0, lut_val};

  // r == 0 means "no factor taken yet": the first accepted factor enters the
  // chain directly as a Q0.32 value rather than being multiplied by 1.0.
  assign cand   = (r_q == 32'd0) ? {lut_val, 16'b0} : prod;
  assign take   = (cand >= y_q);
  assign x_next = take ? (x_q | (X_W'(1) << k_q)) : x_q;

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state   <= LN_IDLE;
      y_q     <= '0;
      x_q     <= '0;
      r_q     <= '0;
      k_q     <= K_START;
      data_q  <= '0;
      sat_q   <= 1'b0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      case (state)
        LN_IDLE: begin
          if (ln.ln_valid_i) begin
            y_q     <= ln.ln_data_i;
            ready_q <= 1'b0;
            if (ln.ln_data_i == 32'd0) begin
              data_q  <= LN_SAT_VALUE;
              sat_q   <= 1'b1;
              valid_q <= 1'b1;
              state   <= LN_DONE;
            end else if (ln.ln_data_i == 32'hFFFF_FFFF) begin
              data_q  <= '0;
              sat_q   <= 1'b0;
              valid_q <= 1'b1;
              state   <= LN_DONE;
            end else begin
              x_q   <= '0;
              r_q   <= '0;
              k_q   <= K_START;
              state <= LN_BUSY;
            end
          end
        end

        LN_BUSY: begin
          x_q <= x_next;
          if (take) begin
            r_q <= cand;
          end
          if (k_q == '0) begin
            data_q  <= {{(32-X_W){1'b0}}, x_next};
            sat_q   <= 1'b0;
            valid_q <= 1'b1;
            state   <= LN_DONE;
          end else begin
            k_q <= k_q - 1'b1;
          end
        end

        LN_DONE: begin
          if (ln.ln_ready_i) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state   <= LN_IDLE;
          end
        end

        default: begin
          valid_q <= 1'b0;
          ready_q <= 1'b1;
          state   <= LN_IDLE;
        end
      endcase
    end
  end

  assign ln.ln_ready_o      = ready_q;
  assign ln.ln_data_valid_o = valid_q;
  assign ln.ln_data_o       = data_q;
  assign ln.ln_sat_o        = sat_q;

endmodule
`default_nettype wire

// File: tb/tb_lut_ln.sv
`default_nettype none
// ============================================================================
//  Module    : tb_lut_ln
//  Purpose   : Self-checking bench for lut_ln. Expected results come from an
//              exponential-block golden model and a greedy search over it.
//  Revision  : 1.0 - initial release
// ============================================================================
module tb_lut_ln;

  logic clock_i   = 1'b0;
  logic reset_n_i = 1'b0;

  always #5 clock_i = ~clock_i;

  lut_ln_if #(.DATA_SIZE(32)) ln_bus ();

  lut_ln dut (
    .clock_i   (clock_i),
    .reset_n_i (reset_n_i),
    .ln        (ln_bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] lut_tab [20];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, want);
    end
  endtask

  // Exponential block golden model: multiply the table factors of every set
  // bit of x, MSB first, truncating each product to 32 bits via r[31:16].
  function automatic logic [31:0] exp_model(input logic [19:0] x);
    logic [31:0] r;
    if (x == 20'd0) return 32'hFFFF_FFFF;
    r = 32'd0;
    for (int k = 19; k >= 0; k--) begin
      if (x[k]) begin
        if (r == 32'd0) r = {lut_tab[k], 16'h0};
        else            r = {16'h0, r[31:16]} * {16'h0, lut_tab[k]};
      end
    end
    return r;
  endfunction

  // Largest x (built greedily MSB first) whose exp_model result is still >= y.
  // Returns {sat, x}.
  function automatic logic [32:0] ln_model(input logic [31:0] y);
    logic [19:0] x;
    logic [19:0] trial;
    if (y == 32'd0)          return {1'b1, 32'h000F_FFFF};
    if (y == 32'hFFFF_FFFF)  return {1'b0, 32'h0};
    x = 20'd0;
    for (int k = 19; k >= 0; k--) begin
      trial = x | (20'd1 << k);
      if (exp_model(trial) >= y) x = trial;
    end
    return {1'b0, 12'h0, x};
  endfunction

  task automatic wait_ready(input string tag);
    int w;
    w = 0;
    while (!ln_bus.ln_ready_o && w < 60) begin
      @(posedge clock_i); #1;
      w++;
    end
    check({tag, "_ready"}, {31'b0, ln_bus.ln_ready_o}, 32'd1);
  endtask

  // Called right after the accept edge (+1); returns cycles until valid.
  task automatic wait_result(output int lat);
    lat = 1;
    while (!ln_bus.ln_data_valid_o && lat < 60) begin
      @(posedge clock_i); #1;
      lat++;
    end
  endtask

  task automatic consume(input string tag);
    ln_bus.ln_ready_i = 1'b1;
    @(posedge clock_i); #1;
    ln_bus.ln_ready_i = 1'b0;
    check({tag, "_idle_valid"}, {31'b0, ln_bus.ln_data_valid_o}, 32'd0);
    check({tag, "_idle_ready"}, {31'b0, ln_bus.ln_ready_o}, 32'd1);
  endtask

  task automatic run_ln(input string tag, input logic [31:0] y, output logic [31:0] got);
    logic [32:0] want;
    int          lat;
    int          want_lat;
    want     = ln_model(y);
    want_lat = (y == 32'd0 || y == 32'hFFFF_FFFF) ? 1 : 21;
    wait_ready(tag);
    ln_bus.ln_valid_i = 1'b1;
    ln_bus.ln_data_i  = y;
    @(posedge clock_i); #1;
    ln_bus.ln_valid_i = 1'b0;
    wait_result(lat);
    check({tag, "_valid"}, {31'b0, ln_bus.ln_data_valid_o}, 32'd1);
    check({tag, "_lat"},   lat, want_lat);
    check({tag, "_data"},  ln_bus.ln_data_o, want[31:0]);
    check({tag, "_sat"},   {31'b0, ln_bus.ln_sat_o}, {31'b0, want[32]});
    got = ln_bus.ln_data_o;
    consume(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got;
    logic [31:0] y;
    logic [31:0] ya;
    logic [31:0] yb;
    logic [19:0] x;
    logic [32:0] want;
    int          lat;

    lut_tab = '{16'hFFFF, 16'hFFFE, 16'hFFFC, 16'hFFF8, 16'hFFF0,
                16'hFFE0, 16'hFFC0, 16'hFF80, 16'hFF00, 16'hFE01,
                16'hFC07, 16'hF81F, 16'hF07D, 16'hE1EB, 16'hC75F,
                16'h9B45, 16'h5E2D, 16'h22A5, 16'h04B0, 16'h0015};

    ln_bus.ln_valid_i = 1'b0;
    ln_bus.ln_data_i  = 32'd0;
    ln_bus.ln_ready_i = 1'b0;

    // Reset state
    #12;
    check("rst_ready", {31'b0, ln_bus.ln_ready_o}, 32'd1);
    check("rst_valid", {31'b0, ln_bus.ln_data_valid_o}, 32'd0);
    check("rst_data",  ln_bus.ln_data_o, 32'd0);
    check("rst_sat",   {31'b0, ln_bus.ln_sat_o}, 32'd0);
    @(negedge clock_i);
    reset_n_i = 1'b1;
    @(posedge clock_i); #1;

    // Directed boundary cases
    run_ln("one",  32'hFFFF_FFFF, got);
    run_ln("zero", 32'h0000_0000, got);
    run_ln("e_m1", 32'h5E2D_0000, got);
    check("e_m1_const", got, 32'h0001_0000);

    // Every single-bit x maps back to itself
    for (int k = 0; k < 20; k++) begin
      x = 20'd1 << k;
      run_ln("bit", exp_model(x), got);
      check("bit_exact", got, {12'h0, x});
    end

    // Random round trip through the exponential model
    for (int i = 0; i < 24; i++) begin
      x = 20'($urandom);
      y = exp_model(x);
      run_ln("rt", y, got);
      check("rt_exp_ge_y", {31'b0, (exp_model(got[19:0]) >= y)}, 32'd1);
    end

    // Random raw y
    for (int i = 0; i < 12; i++) begin
      y = $urandom;
      run_ln("rand", y, got);
    end

    // Backpressure: result held for 10 cycles while a new request waits
    ya = 32'h1234_5678;
    yb = $urandom | 32'h0000_0100;
    if (yb == 32'hFFFF_FFFF) yb = 32'h8000_0001;
    wait_ready("bp");
    ln_bus.ln_valid_i = 1'b1;
    ln_bus.ln_data_i  = ya;
    @(posedge clock_i); #1;
    ln_bus.ln_data_i  = yb;
    wait_result(lat);
    check("bp_lat", lat, 21);
    want = ln_model(ya);
    for (int i = 0; i < 10; i++) begin
      @(posedge clock_i); #1;
      check("bp_hold_valid", {31'b0, ln_bus.ln_data_valid_o}, 32'd1);
      check("bp_hold_data",  ln_bus.ln_data_o, want[31:0]);
      check("bp_hold_ready", {31'b0, ln_bus.ln_ready_o}, 32'd0);
    end
    ln_bus.ln_ready_i = 1'b1;
    @(posedge clock_i); #1;
    ln_bus.ln_ready_i = 1'b0;
    check("bp_bubble_ready", {31'b0, ln_bus.ln_ready_o}, 32'd1);
    check("bp_bubble_valid", {31'b0, ln_bus.ln_data_valid_o}, 32'd0);
    @(posedge clock_i); #1;
    ln_bus.ln_valid_i = 1'b0;
    check("bp_accept", {31'b0, ln_bus.ln_ready_o}, 32'd0);
    wait_result(lat);
    want = ln_model(yb);
    check("bp2_lat",  lat, 21);
    check("bp2_data", ln_bus.ln_data_o, want[31:0]);
    consume("bp2");

    // Reset in the middle of an operation (k = 10)
    run_ln("pre_rst", 32'd0, got);
    wait_ready("mid");
    ln_bus.ln_valid_i = 1'b1;
    ln_bus.ln_data_i  = 32'h4000_0000;
    @(posedge clock_i); #1;
    ln_bus.ln_valid_i = 1'b0;
    for (int i = 0; i < 9; i++) begin
      @(posedge clock_i); #1;
    end
    #2;
    reset_n_i = 1'b0;
    #1;
    check("mid_rst_ready", {31'b0, ln_bus.ln_ready_o}, 32'd1);
    check("mid_rst_valid", {31'b0, ln_bus.ln_data_valid_o}, 32'd0);
    check("mid_rst_data",  ln_bus.ln_data_o, 32'd0);
    check("mid_rst_sat",   {31'b0, ln_bus.ln_sat_o}, 32'd0);
    @(negedge clock_i);
    reset_n_i = 1'b1;
    @(posedge clock_i); #1;
    run_ln("post_rst", 32'h4000_0000, got);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
